test_sequencer: RTL and testbench

//  Parametrised, synthesizable successor to the flat testbench top: runs NUM_TESTS test channels one at a time.
//  Per channel: launch, wait for done or timeout, record pass/fail, then advance. Aggregates counts.

---
 rtl/test_sequencer_pkg.sv | 23 ++
 rtl/test_sequencer_timeout.sv | 41 ++++
 rtl/test_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_test_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_sequencer_pkg.sv
// Shared types and defaults for the test sequencer: FSM state encoding,
// default sizing and the timeout-counter width helper.
package test_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SCAN   = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RECORD = 3'd4,
      ST_FINISH = 3'd5
   } seq_state_e;

   localparam int DEFAULT_NUM_TESTS      = 8;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
   localparam int DEFAULT_IDX_W          = 3;

   // One spare bit so the terminal value never aliases to zero.
   function automatic int tout_cnt_w(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/test_sequencer_timeout.sv
// Per-channel watchdog: cleared on launch, counts while the sequencer waits,
// flags expiry when the count reaches TIMEOUT_CYCLES-1 and then holds.
module test_sequencer_timeout
   import test_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int               CNT_W   = tout_cnt_w(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != CNT_END)) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CNT_END);

endmodule

// File: rtl/test_sequencer.sv
// Runs NUM_TESTS test channels one after another: launch, wait for done or
// timeout, record the verdict, and aggregate pass/fail/timeout results.
module test_sequencer
   import test_sequencer_pkg::*;
#(
   parameter int NUM_TESTS      = DEFAULT_NUM_TESTS,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int IDX_W          = DEFAULT_IDX_W
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [NUM_TESTS-1:0] test_enable_i,
   output logic [NUM_TESTS-1:0] test_start_o,
   input  logic [NUM_TESTS-1:0] test_done_i,
   input  logic [NUM_TESTS-1:0] test_pass_i,
   output logic                 busy_o,
   output logic                 all_done_o,
   output logic [IDX_W-1:0]     cur_idx_o,
   output logic [NUM_TESTS-1:0] pass_vec_o,
   output logic [NUM_TESTS-1:0] fail_vec_o,
   output logic [NUM_TESTS-1:0] tout_vec_o,
   output logic [IDX_W:0]       pass_count_o,
   output logic [IDX_W:0]       fail_count_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

   // Reset asserts immediately but is released only on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   seq_state_e           state_q;
   logic [NUM_TESTS-1:0] mask_q;
   logic [IDX_W-1:0]     cur_idx_q;
   logic [NUM_TESTS-1:0] test_start_q;
   logic                 busy_q;
   logic                 all_done_q;
   logic [NUM_TESTS-1:0] pass_vec_q;
   logic [NUM_TESTS-1:0] fail_vec_q;
   logic [NUM_TESTS-1:0] tout_vec_q;
   logic [IDX_W:0]       pass_count_q;
   logic [IDX_W:0]       fail_count_q;
   logic                 verdict_q;

   logic [NUM_TESTS-1:0] cur_onehot;
   logic                 cur_enabled;
   logic                 cur_done;
   logic                 cur_pass;
   logic                 cur_is_last;
   logic                 tmo_clear;
   logic                 tmo_enable;
   logic                 tmo_expired;

   // Channel select decode; all per-channel inputs are filtered through it so
   // activity on non-current channels never reaches the FSM.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_TESTS; gi++) begin : g_sel
         assign cur_onehot[gi] = (cur_idx_q == IDX_W'(gi));
      end
   endgenerate

   assign cur_enabled = |(mask_q & cur_onehot);
   assign cur_done    = |(test_done_i & cur_onehot);
   assign cur_pass    = |(test_pass_i & test_done_i & cur_onehot);
   assign cur_is_last = (cur_idx_q == LAST_IDX);

   assign tmo_clear   = (state_q == ST_LAUNCH);
   assign tmo_enable  = (state_q == ST_WAIT);

   test_sequencer_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i    (clk_i),
      .rst_ni   (rst_n_int),
      .clear_i  (tmo_clear),
      .enable_i (tmo_enable),
      .expired_o(tmo_expired)
   );

   always_ff @(posedge clk_i or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         cur_idx_q    <= '0;
         test_start_q <= '0;
         busy_q       <= 1'b0;
         all_done_q   <= 1'b0;
         pass_vec_q   <= '0;
         fail_vec_q   <= '0;
         tout_vec_q   <= '0;
         pass_count_q <= '0;
         fail_count_q <= '0;
         verdict_q    <= 1'b0;
      end else begin
         test_start_q <= '0;
         if (abort_i && (state_q != ST_IDLE)) begin
            // Partial results stay visible; the run is simply not completed.
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            all_done_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i && !abort_i) begin
                     mask_q       <= test_enable_i;
                     cur_idx_q    <= '0;
                     pass_vec_q   <= '0;
                     fail_vec_q   <= '0;
                     tout_vec_q   <= '0;
                     pass_count_q <= '0;
                     fail_count_q <= '0;
                     all_done_q   <= 1'b0;
                     busy_q       <= 1'b1;
                     state_q      <= ST_SCAN;
                  end
               end
               ST_SCAN: begin
                  if (cur_enabled) begin
                     test_start_q <= cur_onehot;
                     state_q      <= ST_LAUNCH;
                  end else if (cur_is_last) begin
                     state_q <= ST_FINISH;
                  end else begin
                     cur_idx_q <= cur_idx_q + IDX_ONE;
                  end
               end
               ST_LAUNCH: begin
                  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  // A verdict arriving on the last counted cycle beats the timeout.
                  if (cur_done) begin
                     verdict_q <= cur_pass;
                     state_q   <= ST_RECORD;
                  end else if (tmo_expired) begin
                     verdict_q  <= 1'b0;
                     tout_vec_q <= tout_vec_q | cur_onehot;
                     state_q    <= ST_RECORD;
                  end
               end
               ST_RECORD: begin
                  if (verdict_q) begin
                     pass_vec_q   <= pass_vec_q | cur_onehot;
                     pass_count_q <= pass_count_q + CNT_ONE;
                  end else begin
                     fail_vec_q   <= fail_vec_q | cur_onehot;
                     fail_count_q <= fail_count_q + CNT_ONE;
                  end
                  if (cur_is_last) begin
                     state_q <= ST_FINISH;
                  end else begin
                     cur_idx_q <= cur_idx_q + IDX_ONE;
                     state_q   <= ST_SCAN;
                  end
               end
               ST_FINISH: begin
                  all_done_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign test_start_o = test_start_q;
   assign busy_o       = busy_q;
   assign all_done_o   = all_done_q;
   assign cur_idx_o    = cur_idx_q;
   assign pass_vec_o   = pass_vec_q;
   assign fail_vec_o   = fail_vec_q;
   assign tout_vec_o   = tout_vec_q;
   assign pass_count_o = pass_count_q;
   assign fail_count_o = fail_count_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer (4 channels, 16-cycle timeout): table of directed
// runs, hand-written abort/reset sequences and random runs against a model.
module tb_test_sequencer;

   localparam int NT    = 4;
   localparam int TO    = 16;
   localparam int IW    = 2;
   localparam int NEVER = 255;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NT-1:0] test_enable = '0;
   logic [NT-1:0] test_start;
   logic [NT-1:0] test_done = '0;
   logic [NT-1:0] test_pass = '0;
   logic          busy;
   logic          all_done;
   logic [IW-1:0] cur_idx;
   logic [NT-1:0] pass_vec;
   logic [NT-1:0] fail_vec;
   logic [NT-1:0] tout_vec;
   logic [IW:0]   pass_count;
   logic [IW:0]   fail_count;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int            cfg_dly [NT];
   logic [NT-1:0] cfg_pas;
   int            cnt_dn [NT];
   logic [NT-1:0] launched;
   int            multi_err;
   int            first_launch;

   typedef struct packed {
      logic [NT-1:0]      mask;
      logic [NT-1:0][7:0] dly;
      logic [NT-1:0]      pas;
      logic [NT-1:0]      e_pass;
      logic [NT-1:0]      e_fail;
      logic [NT-1:0]      e_tout;
      logic [7:0]         e_pc;
      logic [7:0]         e_fc;
      logic [7:0]         e_cyc;
   } vec_t;

   vec_t tbl [8];

   test_sequencer #(
      .NUM_TESTS(NT),
      .TIMEOUT_CYCLES(TO),
      .IDX_W(IW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .abort_i      (abort),
      .test_enable_i(test_enable),
      .test_start_o (test_start),
      .test_done_i  (test_done),
      .test_pass_i  (test_pass),
      .busy_o       (busy),
      .all_done_o   (all_done),
      .cur_idx_o    (cur_idx),
      .pass_vec_o   (pass_vec),
      .fail_vec_o   (fail_vec),
      .tout_vec_o   (tout_vec),
      .pass_count_o (pass_count),
      .fail_count_o (fail_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // Channel responder: a launched channel pulses done (with its verdict) for one
   // cycle, dly cycles after its launch cycle; dly=0 pulses inside the launch cycle.
   initial begin
      for (int i = 0; i < NT; i++) begin
         cnt_dn[i]  = 0;
         cfg_dly[i] = 0;
      end
      cfg_pas = '0;
      launched = '0;
      multi_err = 0;
      first_launch = -1;
      forever begin
         @(negedge clk);
         test_done = '0;
         test_pass = '0;
         for (int i = 0; i < NT; i++) begin
            if (cnt_dn[i] > 0) begin
               cnt_dn[i]--;
               if (cnt_dn[i] == 0) begin
                  test_done[i] = 1'b1;
                  test_pass[i] = cfg_pas[i];
               end
            end
         end
         if (test_start != '0) begin
            if ($countones(test_start) != 1) multi_err++;
            if (first_launch < 0) first_launch = cyc;
            launched = launched | test_start;
            for (int i = 0; i < NT; i++) begin
               if (test_start[i]) begin
                  if (cfg_dly[i] == 0) begin
                     test_done[i] = 1'b1;
                     test_pass[i] = cfg_pas[i];
                  end else if (cfg_dly[i] < NEVER) begin
                     cnt_dn[i] = cfg_dly[i];
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [NT-1:0] m, input logic [NT-1:0][7:0] d,
                               input logic [NT-1:0] p, input logic [NT-1:0] ep,
                               input logic [NT-1:0] ef, input logic [NT-1:0] et,
                               input int pc, input int fc, input int cy);
      vec_t v;
      v.mask = m; v.dly = d; v.pas = p;
      v.e_pass = ep; v.e_fail = ef; v.e_tout = et;
      v.e_pc = 8'(pc); v.e_fc = 8'(fc); v.e_cyc = 8'(cy);
      return v;
   endfunction

   // Reference: an enabled channel answering within 1..TO wait cycles gets its
   // verdict, otherwise it times out after TO wait cycles. Enabled channels cost
   // scan+launch+wait+record cycles, skipped ones a single scan cycle, plus finish.
   task automatic model(input logic [NT-1:0] m, output logic [NT-1:0] ep,
                        output logic [NT-1:0] ef, output logic [NT-1:0] et,
                        output int pc, output int fc, output int cy);
      ep = '0; ef = '0; et = '0; pc = 0; fc = 0; cy = 1;
      for (int i = 0; i < NT; i++) begin
         if (!m[i]) begin
            cy += 1;
         end else if (cfg_dly[i] >= 1 && cfg_dly[i] <= TO) begin
            cy += 3 + cfg_dly[i];
            if (cfg_pas[i]) begin ep[i] = 1'b1; pc++; end
            else begin ef[i] = 1'b1; fc++; end
         end else begin
            cy += 3 + TO;
            ef[i] = 1'b1; et[i] = 1'b1; fc++;
         end
      end
   endtask

   task automatic begin_run(input logic [NT-1:0] m, output int s);
      for (int i = 0; i < NT; i++) cnt_dn[i] = 0;
      launched = '0;
      multi_err = 0;
      first_launch = -1;
      test_enable = m;
      start = 1'b1;
      s = cyc;
      @(negedge clk);
      start = 1'b0;
      test_enable = NT'($urandom);
   endtask

   task automatic run_and_check(input string tag, input logic [NT-1:0] m, input bit poke,
                                input logic [NT-1:0] ep, input logic [NT-1:0] ef,
                                input logic [NT-1:0] et, input int epc, input int efc,
                                input int ecy);
      int s;
      int n;
      begin_run(m, s);
      chk({tag, "_busy_on"}, 32'(busy), 1);
      chk({tag, "_cleared"}, {all_done, pass_vec, fail_vec, tout_vec}, 0);
      n = -1;
      for (int k = 0; k < 400; k++) begin
         start = poke && (k == 3);
         if (all_done === 1'b1) begin
            n = cyc - s - 1;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (n < 0) begin
         chk({tag, "_finished"}, 32'(all_done), 1);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end else begin
         chk({tag, "_cycles"}, n, ecy);
         chk({tag, "_pass_vec"}, 32'(pass_vec), 32'(ep));
         chk({tag, "_fail_vec"}, 32'(fail_vec), 32'(ef));
         chk({tag, "_tout_vec"}, 32'(tout_vec), 32'(et));
         chk({tag, "_pass_cnt"}, 32'(pass_count), epc);
         chk({tag, "_fail_cnt"}, 32'(fail_count), efc);
         chk({tag, "_busy_off"}, 32'(busy), 0);
         chk({tag, "_cur_idx"}, 32'(cur_idx), NT - 1);
         chk({tag, "_launched"}, 32'(launched), 32'(m));
         chk({tag, "_onehot"}, multi_err, 0);
         if (m[0]) chk({tag, "_latency"}, first_launch - s, 2);
         @(negedge clk);
         @(negedge clk);
         chk({tag, "_done_held"}, {test_start, busy, all_done}, 1);
      end
      $display("run %s mask=%h cycles=%0d pass=%h fail=%h tout=%h pc=%0d fc=%0d",
               tag, m, n, pass_vec, fail_vec, tout_vec, pass_count, fail_count);
   endtask

   task automatic wait_launch(input int ch, input string tag);
      for (int k = 0; k < 200; k++) begin
         if (launched[ch]) break;
         @(negedge clk);
      end
      chk({tag, "_launch_seen"}, 32'(launched[ch]), 1);
   endtask

   initial begin
      logic [NT-1:0] ep, ef, et;
      logic [NT-1:0] m;
      int pc, fc, cy, r, s;

      tbl[0] = mk(4'hF, {8'd3, 8'd3, 8'd3, 8'd3}, 4'hF, 4'hF, 4'h0, 4'h0, 4, 0, 25);
      tbl[1] = mk(4'hF, {8'd3, 8'd255, 8'd3, 8'd3}, 4'hD, 4'h9, 4'h6, 4'h4, 2, 2, 38);
      tbl[2] = mk(4'hA, {8'd3, 8'd3, 8'd3, 8'd3}, 4'hF, 4'hA, 4'h0, 4'h0, 2, 0, 15);
      tbl[3] = mk(4'h1, {8'd1, 8'd1, 8'd1, 8'd16}, 4'hF, 4'h1, 4'h0, 4'h0, 1, 0, 23);
      tbl[4] = mk(4'h1, {8'd1, 8'd1, 8'd1, 8'd0}, 4'hF, 4'h0, 4'h1, 4'h1, 0, 1, 23);
      tbl[5] = mk(4'h3, {8'd1, 8'd1, 8'd1, 8'd17}, 4'hF, 4'h2, 4'h1, 4'h1, 1, 1, 26);
      tbl[6] = mk(4'h0, {8'd3, 8'd3, 8'd3, 8'd3}, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 5);
      tbl[7] = mk(4'h8, {8'd1, 8'd2, 8'd3, 8'd4}, 4'h7, 4'h0, 4'h8, 4'h0, 0, 1, 8);

      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_outputs", {busy, all_done, cur_idx, pass_vec, fail_vec, tout_vec,
                            pass_count, fail_count, test_start}, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_after_reset", {busy, all_done, test_start}, 0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < NT; i++) cfg_dly[i] = int'(tbl[t].dly[i]);
         cfg_pas = tbl[t].pas;
         run_and_check($sformatf("tbl%0d", t), tbl[t].mask, t == 0, tbl[t].e_pass,
                       tbl[t].e_fail, tbl[t].e_tout, int'(tbl[t].e_pc),
                       int'(tbl[t].e_fc), int'(tbl[t].e_cyc));
         repeat (2) @(negedge clk);
      end

      // Abort during channel 2's wait; start in the same cycle must be dropped.
      cfg_dly[0] = 3; cfg_dly[1] = 3; cfg_dly[2] = NEVER; cfg_dly[3] = 3;
      cfg_pas = 4'hF;
      begin_run(4'hF, s);
      wait_launch(2, "abort");
      repeat (3) @(negedge clk);
      chk("abort_pre_busy", 32'(busy), 1);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_all_done", 32'(all_done), 0);
      chk("abort_test_start", 32'(test_start), 0);
      chk("abort_pass_vec", 32'(pass_vec), 32'h3);
      chk("abort_counts", {pass_count, fail_count}, {3'd2, 3'd0});
      repeat (3) @(negedge clk);
      chk("abort_start_dropped", {busy, test_start}, 0);
      $display("run abort pass=%h pc=%0d busy=%0d", pass_vec, pass_count, busy);
      cfg_dly[2] = 3;
      run_and_check("rerun", 4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 4, 0, 25);
      repeat (2) @(negedge clk);

      // Asynchronous reset while channel 1 is being awaited.
      cfg_dly[0] = 5; cfg_dly[1] = 5; cfg_dly[2] = 5; cfg_dly[3] = 5;
      begin_run(4'hF, s);
      wait_launch(1, "rst");
      @(negedge clk);
      chk("rst_pre_pass", 32'(pass_vec), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {busy, all_done, cur_idx, pass_vec, fail_vec, tout_vec,
                        pass_count, fail_count, test_start}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_idle", {busy, all_done, pass_vec, test_start}, 0);
      $display("run reset busy=%0d pass=%h", busy, pass_vec);

      for (int t = 0; t < 30; t++) begin
         m = NT'($urandom);
         for (int i = 0; i < NT; i++) begin
            r = int'($urandom_range(0, 20));
            cfg_dly[i] = (r > 18) ? NEVER : r;
         end
         cfg_pas = NT'($urandom);
         model(m, ep, ef, et, pc, fc, cy);
         run_and_check($sformatf("rnd%0d", t), m, (m != '0) && ($urandom_range(0, 1) == 1),
                       ep, ef, et, pc, fc, cy);
         repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
